// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 4-bit add/sub/and/or ALU between two requesters.
// Round-robin grant in IDLE, one cycle of execution, then the result is held
// on the owner's response channel until it is accepted.

// Combinational ALU; carry is the 5th result bit (borrow for sub).
module alu #(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] a_i,
  input  logic [OPW-1:0] b_i,
  input  logic [1:0]     sel_i,
  output logic [OPW-1:0] out_o,
  output logic           carry_out_o
);
  logic [OPW:0] res;

  // add/sub are computed one bit wider so the top bit is carry or borrow
  always_comb begin
    res = '0;
    case (sel_i)
      2'b00:   res = {1'b0, a_i} + {1'b0, b_i};
      2'b01:   res = {1'b0, a_i} - {1'b0, b_i};
      2'b10:   res = {1'b0, a_i & b_i};
      default: res = {1'b0, a_i | b_i};
    endcase
  end

  assign out_o       = res[OPW-1:0];
  assign carry_out_o = res[OPW];
endmodule

module alu_arbiter #(
  parameter int OPW  = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [OPW-1:0]  req_a0,
  input  logic [OPW-1:0]  req_b0,
  input  logic [OPW-1:0]  req_a1,
  input  logic [OPW-1:0]  req_b1,
  input  logic [1:0]      req_sel0,
  input  logic [1:0]      req_sel1,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [OPW-1:0]  rsp_out,
  output logic            rsp_carry,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic            prio_q, prio_d;
  logic            owner_q, owner_d;
  logic [OPW-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]      sel_q, sel_d;
  logic [OPW-1:0]  out_q, out_d;
  logic            carry_q, carry_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // requester operands packed so the grant index selects them directly
  logic [1:0][OPW-1:0] req_a, req_b;
  logic [1:0][1:0]     req_sel;
  assign req_a   = {req_a1, req_a0};
  assign req_b   = {req_b1, req_b0};
  assign req_sel = {req_sel1, req_sel0};

  // prio only breaks ties; a lone valid requester always wins
  logic gnt;
  assign gnt = (&req_valid) ? prio_q : req_valid[1];

  logic [OPW-1:0] alu_out;
  logic           alu_carry;

  alu #(.OPW(OPW)) u_alu (
    .a_i         (a_q),
    .b_i         (b_q),
    .sel_i       (sel_q),
    .out_o       (alu_out),
    .carry_out_o (alu_carry)
  );

  // next-state and handshake outputs; rst suppresses req_ready immediately
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    out_d     = out_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid && !rst) begin
          req_ready[gnt] = 1'b1;
          a_d            = req_a[gnt];
          b_d            = req_b[gnt];
          sel_d          = req_sel[gnt];
          owner_d        = gnt;
          prio_d         = ~gnt;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        out_d   = alu_out;
        carry_d = alu_carry;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          cnt_d   = cnt_q + CNTW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers with synchronous reset that aborts any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_out   = out_q;
  assign rsp_carry = carry_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: random operands against a behavioural model of the
// ALU, the round-robin grant and the completion counter. A second instance
// with a 2-bit counter shares the stimulus to exercise counter wrap.
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b11;
  logic [1:0] rsp_ready = 2'b00;
  logic [3:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0] req_sel0 = '0, req_sel1 = '0;

  logic [1:0] req_ready, rsp_valid;
  logic [3:0] rsp_out;
  logic       rsp_carry, busy;
  logic [7:0] op_count;

  logic [1:0] req_ready_w, rsp_valid_w;
  logic [3:0] rsp_out_w;
  logic       rsp_carry_w, busy_w;
  logic [1:0] op_count_w;

  int checks = 0;
  int failures = 0;
  int prio_m = 0;   // requester favoured on the next tie
  int cnt_m = 0;    // completed responses since reset

  always #5 clk = ~clk;

  alu_arbiter #(.OPW(4), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_sel0(req_sel0), .req_sel1(req_sel1), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_carry(rsp_carry),
    .busy(busy), .op_count(op_count)
  );

  alu_arbiter #(.OPW(4), .CNTW(2)) dut_w (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_w),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_sel0(req_sel0), .req_sel1(req_sel1), .rsp_valid(rsp_valid_w),
    .rsp_ready(rsp_ready), .rsp_out(rsp_out_w), .rsp_carry(rsp_carry_w),
    .busy(busy_w), .op_count(op_count_w)
  );

  // reference result {carry,out} from plain integer arithmetic
  function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] s);
    int x;
    case (s)
      2'd0: x = int'(a) + int'(b);
      2'd1: begin
        x = int'(a) - int'(b);
        if (x < 0) x = x + 32;
      end
      2'd2: x = int'(a & b);
      default: x = int'(a | b);
    endcase
    return x[4:0];
  endfunction

  task automatic set_ops(input int r, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] s);
    if (r == 0) begin req_a0 = a; req_b0 = b; req_sel0 = s; end
    else        begin req_a1 = a; req_b1 = b; req_sel1 = s; end
  endtask

  task automatic rand_ops(input int r);
    set_ops(r, 4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    prio_m = 0; cnt_m = 0;
  endtask

  // one uncontended operation with rsp_ready held high; returns observations
  task automatic single_op(input int r, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] s, output logic [1:0] rdy,
                           output logic [1:0] vexec, output logic [1:0] vld,
                           output logic [4:0] res);
    @(negedge clk);
    set_ops(r, a, b, s);
    req_valid = (r == 0) ? 2'b01 : 2'b10;
    rsp_ready = 2'b11;
    #1 rdy = req_ready;
    @(posedge clk);
    prio_m = 1 - r;
    @(negedge clk);
    req_valid = 2'b00;
    vexec = rsp_valid;
    @(posedge clk);
    @(negedge clk);
    vld = rsp_valid;
    res = {rsp_carry, rsp_out};
    @(posedge clk);
    cnt_m++;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if ({rsp_carry, rsp_out} !== 5'd0) begin failures++; $display("FAIL reset_rsp got=%h exp=00", {rsp_carry, rsp_out}); end
    checks++; if (op_count !== 8'd0 || op_count_w !== 2'd0) begin failures++; $display("FAIL reset_op_count got=%0d/%0d exp=0/0", op_count, op_count_w); end
    rst = 1'b0; req_valid = 2'b00;
    prio_m = 0; cnt_m = 0;
  endtask

  task automatic test_single();
    logic [1:0] rdy, vexec, vld;
    logic [4:0] res;
    logic [3:0] av[2] = '{4'b0011, 4'b0100};
    logic [3:0] bv[2] = '{4'b0001, 4'b0010};
    logic [1:0] sv[2] = '{2'b00, 2'b01};
    for (int i = 0; i < 2; i++) begin
      single_op(0, av[i], bv[i], sv[i], rdy, vexec, vld, res);
      checks++; if (rdy !== 2'b01) begin failures++; $display("FAIL single_req_ready got=%b exp=01", rdy); end
      checks++; if (vexec !== 2'b00) begin failures++; $display("FAIL single_exec_valid got=%b exp=00", vexec); end
      checks++; if (vld !== 2'b01) begin failures++; $display("FAIL single_rsp_valid got=%b exp=01", vld); end
      checks++; if (res !== alu_ref(av[i], bv[i], sv[i])) begin failures++; $display("FAIL single_result got=%h exp=%h", res, alu_ref(av[i], bv[i], sv[i])); end
      checks++; if (op_count !== 8'(cnt_m)) begin failures++; $display("FAIL single_op_count got=%0d exp=%0d", op_count, cnt_m); end
    end
  endtask

  task automatic test_logic();
    logic [1:0] rdy, vexec, vld;
    logic [4:0] res;
    logic [3:0] av[6] = '{4'b1100, 4'b1100, 4'b1111, 4'b0010, 4'h0, 4'h0};
    logic [3:0] bv[6] = '{4'b1010, 4'b1010, 4'b0001, 4'b0100, 4'h0, 4'h0};
    logic [1:0] sv[6] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01};
    for (int i = 4; i < 6; i++) begin
      av[i] = 4'($urandom_range(15)); bv[i] = 4'($urandom_range(15));
    end
    for (int i = 0; i < 6; i++) begin
      single_op(1, av[i], bv[i], sv[i], rdy, vexec, vld, res);
      checks++; if (rdy !== 2'b10) begin failures++; $display("FAIL logic_req_ready got=%b exp=10", rdy); end
      checks++; if (vld !== 2'b10) begin failures++; $display("FAIL logic_rsp_valid got=%b exp=10", vld); end
      checks++; if (res !== alu_ref(av[i], bv[i], sv[i])) begin failures++; $display("FAIL logic_result op%0d got=%h exp=%h", i, res, alu_ref(av[i], bv[i], sv[i])); end
    end
  endtask

  task automatic test_contention();
    int g;
    logic [1:0] gmask;
    logic [4:0] exp;
    do_reset();
    rand_ops(0); rand_ops(1);
    for (int i = 0; i < 6; i++) begin
      req_valid = 2'b11; rsp_ready = 2'b11;
      #1;
      g = prio_m;
      gmask = (g == 0) ? 2'b01 : 2'b10;
      exp = (g == 0) ? alu_ref(req_a0, req_b0, req_sel0) : alu_ref(req_a1, req_b1, req_sel1);
      checks++; if (req_ready !== gmask) begin failures++; $display("FAIL contention_grant op%0d got=%b exp=%b", i, req_ready, gmask); end
      @(posedge clk);
      prio_m = 1 - g;
      @(negedge clk);
      rand_ops(g);
      @(posedge clk);
      @(negedge clk);
      checks++; if (rsp_valid !== gmask) begin failures++; $display("FAIL contention_rsp_valid op%0d got=%b exp=%b", i, rsp_valid, gmask); end
      checks++; if ({rsp_carry, rsp_out} !== exp) begin failures++; $display("FAIL contention_result op%0d got=%h exp=%h", i, {rsp_carry, rsp_out}, exp); end
      @(posedge clk);
      cnt_m++;
      @(negedge clk);
    end
    req_valid = 2'b00;
    #1;
    checks++; if (op_count !== 8'(cnt_m)) begin failures++; $display("FAIL contention_op_count got=%0d exp=%0d", op_count, cnt_m); end
  endtask

  task automatic test_backpressure();
    logic [4:0] exp0, exp1;
    int base;
    @(negedge clk);
    base = cnt_m;
    rand_ops(0);
    exp0 = alu_ref(req_a0, req_b0, req_sel0);
    req_valid = 2'b01; rsp_ready = 2'b10;   // non-owner ready must be ignored
    @(posedge clk);
    prio_m = 1;
    @(negedge clk);
    rand_ops(1);
    exp1 = alu_ref(req_a1, req_b1, req_sel1);
    req_valid = 2'b10;                      // requester 1 waits through the stall
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 2'b01 || {rsp_carry, rsp_out} !== exp0) begin failures++; $display("FAIL stall_rsp cyc%0d got=%b/%h exp=01/%h", k, rsp_valid, {rsp_carry, rsp_out}, exp0); end
      checks++; if (req_ready !== 2'b00 || busy !== 1'b1) begin failures++; $display("FAIL stall_ready_busy cyc%0d got=%b/%b exp=00/1", k, req_ready, busy); end
      checks++; if (op_count !== 8'(base)) begin failures++; $display("FAIL stall_op_count got=%0d exp=%0d", op_count, base); end
      @(posedge clk);
    end
    @(negedge clk);
    rsp_ready = 2'b01;
    @(posedge clk);
    cnt_m++;
    #1;
    checks++; if (rsp_valid !== 2'b00 || op_count !== 8'(cnt_m)) begin failures++; $display("FAIL stall_release got=%b/%0d exp=00/%0d", rsp_valid, op_count, cnt_m); end
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL stall_next_grant got=%b exp=10", req_ready); end
    @(posedge clk);
    prio_m = 0;
    @(negedge clk);
    req_valid = 2'b00; rsp_ready = 2'b11;
    @(posedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b10 || {rsp_carry, rsp_out} !== exp1) begin failures++; $display("FAIL stall_followup got=%b/%h exp=10/%h", rsp_valid, {rsp_carry, rsp_out}, exp1); end
    @(posedge clk);
    cnt_m++;
    #1;
  endtask

  task automatic test_reset_mid();
    int seen;
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      set_ops(0, 4'd5, 4'd6, 2'b00);
      req_valid = 2'b01; rsp_ready = 2'b00;
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      if (ph == 1) begin
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 2'b01 || rsp_out !== 4'hB) begin failures++; $display("FAIL midrst_in_resp got=%b/%h exp=01/b", rsp_valid, rsp_out); end
      end else begin
        checks++; if (busy !== 1'b1 || rsp_valid !== 2'b00) begin failures++; $display("FAIL midrst_in_exec got=%b/%b exp=1/00", busy, rsp_valid); end
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin failures++; $display("FAIL midrst_ctrl ph%0d got=%b/%b/%b exp=0/00/00", ph, busy, rsp_valid, req_ready); end
      checks++; if ({rsp_carry, rsp_out} !== 5'd0 || op_count !== 8'd0) begin failures++; $display("FAIL midrst_data ph%0d got=%h/%0d exp=00/0", ph, {rsp_carry, rsp_out}, op_count); end
      seen = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (rsp_valid !== 2'b00) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_response ph%0d got=%0d exp=0", ph, seen); end
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL midrst_prio ph%0d got=%b exp=01", ph, req_ready); end
      req_valid = 2'b00;
    end
  endtask

  task automatic test_wrap();
    logic [1:0] rdy, vexec, vld;
    logic [4:0] res;
    int r;
    logic [3:0] a, b;
    logic [1:0] s;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      r = int'($urandom_range(1));
      a = 4'($urandom_range(15)); b = 4'($urandom_range(15)); s = 2'($urandom_range(3));
      single_op(r, a, b, s, rdy, vexec, vld, res);
      checks++; if (op_count_w !== 2'(k % 4)) begin failures++; $display("FAIL wrap_op_count k%0d got=%0d exp=%0d", k, op_count_w, k % 4); end
      checks++; if (res !== alu_ref(a, b, s)) begin failures++; $display("FAIL wrap_result k%0d got=%h exp=%h", k, res, alu_ref(a, b, s)); end
    end
    checks++; if (op_count !== 8'(cnt_m)) begin failures++; $display("FAIL wrap_wide_count got=%0d exp=%0d", op_count, cnt_m); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_logic();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and round-robin arbiter that shares one instance of the 4-bit combinational `alu` (add/sub/and/or) between two requesters. Each requester issues operations over a valid/ready request channel and receives the result over a valid/ready response channel. The block registers operands, drives the ALU, captures `out`/`carry_out`, and returns them to the originating requester. It sits between the two client blocks and the shared ALU datapath.

## Interface
- `OPW`, default 4: operand/result width; fixed to 4 to match `alu`.
- `CNTW`, default 8: width of the completed-operation counter.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid[1:0]` input 2: request valid, per requester (index 0, 1).
- `req_ready[1:0]` output 2: request accepted this cycle, per requester.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` input 4 each: operands for requesters 0 and 1.
- `req_sel0`, `req_sel1` input 2 each: op select; 00 add, 01 sub, 10 and, 11 or.
- `rsp_valid[1:0]` output 2: response valid, per requester.
- `rsp_ready[1:0]` input 2: requester accepts response.
- `rsp_out` output 4: result, shared by both responses.
- `rsp_carry` output 1: carry/borrow, shared by both responses.
- `busy` output 1: high in any state other than IDLE.
- `op_count` output CNTW: number of completed response handshakes; wraps modulo 2^CNTW.

## Operation
- States: IDLE, EXEC, RESP.
- **IDLE**
  - `req_ready` asserts combinationally for at most one requester: the one holding grant.
  - Grant selection:
    - Only one `req_valid` high: grant that requester.
    - Both high: grant the requester indexed by `prio`.
  - On handshake (`req_valid[g] & req_ready[g]`):
    - Latch a, b, sel into operand registers.
    - Latch g into `owner`.
    - Set `prio` to !g.
    - Go to EXEC.
  - No valid request: remain in IDLE.
- **EXEC**
  - Operand registers drive the ALU.
  - At the end of the cycle, capture ALU `out` into `rsp_out` and `carry_out` into `rsp_carry`.
  - Go to RESP.
- **RESP**
  - `rsp_valid[owner]` high, other bit low.
  - `rsp_out` and `rsp_carry` hold stable until the handshake.
  - On `rsp_ready[owner]`:
    - Increment `op_count`.
    - Go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- ALU arithmetic:
  - Add: {carry,out} = a + b, 5-bit.
  - Sub: {carry,out} = {0,a} − {0,b}, 5-bit; carry=1 means borrow (a<b).
  - And/or: carry=0.
- Requests are never dropped. A requester holding `req_valid` keeps its operands stable until `req_ready`. While the block is busy, `req_ready` stays 0 for both requesters.

## Timing
- Reset (synchronous, takes effect at the rising edge with `rst`=1):
  - State IDLE, `prio`=0, `owner`=0, operand registers 0.
  - `rsp_out`=0, `rsp_carry`=0, `rsp_valid`=00, `req_ready`=00 while `rst` is high, `busy`=0, `op_count`=0.
- Latency: request handshake at edge T; `rsp_valid` high from T+2 (after EXEC at T+1).
- Minimum issue interval is 3 cycles per operation (IDLE→EXEC→RESP, with `rsp_ready` held high).
- Back-to-back contention with both requesters continuously valid: grants strictly alternate 0,1,0,1…
- Reset mid-operation (EXEC or RESP) aborts the operation:
  - No response is issued.
  - `op_count` is not incremented.
  - `prio` returns to 0.
- `req_ready` never asserts in EXEC or RESP. `rsp_valid` never asserts outside RESP.
- `op_count` wraps from 2^CNTW−1 to 0 without a flag.

## Test plan
- Single request, requester 0: a=0011, b=0001, sel=00 → `rsp_valid[0]` at T+2, out=0100, carry=0. Then a=0100, b=0010, sel=01 → out=0010, carry=0.
- Logic and overflow, requester 1:
  - 1100 & 1010 → 1000, carry 0.
  - 1100 | 1010 → 1110, carry 0.
  - 1111 + 0001 → 0000, carry 1.
  - 0010 − 0100 → 1110, carry 1.
- Contention: both `req_valid` high continuously for 6 ops after reset → grant order 0,1,0,1,0,1. Each response lands on the correct `rsp_valid` bit with that requester's result. `op_count`=6.
- Response backpressure: hold `rsp_ready[owner]`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_out`, `rsp_carry` stable. `req_ready`=00. `busy`=1. Completion happens on the cycle `rsp_ready` rises. Also assert the non-owner's `rsp_ready` during the stall → no effect.
- Reset mid-operation: assert `rst` for 1 cycle during EXEC, and again separately during RESP → all outputs at reset values on the next cycle. No response is issued. `op_count` unchanged from 0. Next simultaneous request is granted to requester 0.
- Counter wrap: with CNTW=2, complete 5 ops → `op_count` sequence 1,2,3,0,1.
